// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - register-file address map, geometry and move-sequencer state type
package rf_pkg;

    // Register-file geometry: 256 RAM rows plus the memory-mapped unit windows.
    localparam int RF_ADDR_W    = 9;
    localparam int RF_DATA_W    = 1408;
    localparam int RF_LEN_W     = 8;
    localparam int RF_RAM_DEPTH = 256;

    // StMM X load windows
    localparam logic [RF_ADDR_W-1:0] STMM_0_X = 9'h100;
    localparam logic [RF_ADDR_W-1:0] STMM_1_X = 9'h101;
    localparam logic [RF_ADDR_W-1:0] STMM_2_X = 9'h102;
    localparam logic [RF_ADDR_W-1:0] STMM_3_X = 9'h103;

    // LayerNorm X load windows
    localparam logic [RF_ADDR_W-1:0] LN_0_X = 9'h110;
    localparam logic [RF_ADDR_W-1:0] LN_1_X = 9'h111;
    localparam logic [RF_ADDR_W-1:0] LN_2_X = 9'h112;
    localparam logic [RF_ADDR_W-1:0] LN_3_X = 9'h113;

    // SiLU X load windows
    localparam logic [RF_ADDR_W-1:0] SILU_0_X = 9'h120;
    localparam logic [RF_ADDR_W-1:0] SILU_1_X = 9'h121;
    localparam logic [RF_ADDR_W-1:0] SILU_2_X = 9'h122;
    localparam logic [RF_ADDR_W-1:0] SILU_3_X = 9'h123;

    // Attention Q load windows
    localparam logic [RF_ADDR_W-1:0] ATT_0_Q = 9'h130;
    localparam logic [RF_ADDR_W-1:0] ATT_1_Q = 9'h131;
    localparam logic [RF_ADDR_W-1:0] ATT_2_Q = 9'h132;
    localparam logic [RF_ADDR_W-1:0] ATT_3_Q = 9'h133;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2
    } seq_state_t;

endpackage

// File: rtl/rf_move_seq.sv
// rtl/rf_move_seq.sv - command-driven row copy sequencer owning the register-file port
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   cmd_valid/cmd_ready        command handshake (ready only in IDLE)
//   cmd_src/cmd_dst/cmd_len    first source row, first destination row, row count
//   cmd_src_inc/cmd_dst_inc    per-row address increment enables
//   hold                       stall request
//   busy, done                 command in progress, one-cycle completion pulse
//   rf_addr/rf_we/rf_d/rf_q    register-file port (rf_q valid one cycle after rf_addr)
module rf_move_seq
    import rf_pkg::*;
#(
    parameter int ADDR_W = RF_ADDR_W,
    parameter int DATA_W = RF_DATA_W,
    parameter int LEN_W  = RF_LEN_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_src,
    input  logic [ADDR_W-1:0] cmd_dst,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic              cmd_src_inc,
    input  logic              cmd_dst_inc,
    input  logic              hold,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] rf_addr,
    output logic              rf_we,
    output logic [DATA_W-1:0] rf_d,
    input  logic [DATA_W-1:0] rf_q
);

    seq_state_t        state_q, state_d;
    logic [ADDR_W-1:0] src_q, src_d;
    logic [ADDR_W-1:0] dst_q, dst_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic              src_inc_q, src_inc_d;
    logic              dst_inc_q, dst_inc_d;
    logic              done_q, done_d;

    always_comb begin
        state_d   = state_q;
        src_d     = src_q;
        dst_d     = dst_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        src_inc_d = src_inc_q;
        dst_inc_d = dst_inc_q;
        done_d    = 1'b0;
        cmd_ready = 1'b0;
        rf_addr   = '0;
        rf_we     = 1'b0;
        rf_d      = '0;

        case (state_q)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    src_d     = cmd_src;
                    dst_d     = cmd_dst;
                    len_d     = cmd_len;
                    src_inc_d = cmd_src_inc;
                    dst_inc_d = cmd_dst_inc;
                    cnt_d     = '0;
                    if (cmd_len == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = RD;
                    end
                end
            end
            RD: begin
                rf_addr = src_q;
                if (!hold) begin
                    state_d = WR;
                end
            end
            WR: begin
                rf_addr = dst_q;
                rf_d    = rf_q;
                // Gating with rst_n keeps a reset asserted in a WR cycle from
                // landing a partial row in the destination.
                rf_we   = !hold && rst_n;
                if (hold) begin
                    // rf_q is only held for one cycle, so the row must be re-read.
                    state_d = RD;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    src_d = src_q + {{(ADDR_W-1){1'b0}}, src_inc_q};
                    dst_d = dst_q + {{(ADDR_W-1){1'b0}}, dst_inc_q};
                    if (cnt_d == len_q) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = RD;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            src_q     <= '0;
            dst_q     <= '0;
            len_q     <= '0;
            cnt_q     <= '0;
            src_inc_q <= 1'b0;
            dst_inc_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            src_q     <= src_d;
            dst_q     <= dst_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            src_inc_q <= src_inc_d;
            dst_inc_q <= dst_inc_d;
            done_q    <= done_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign done = done_q;

endmodule

// File: tb/tb_rf_move_seq.sv
// tb/tb_rf_move_seq.sv - scoreboard bench for rf_move_seq with a register-file model
module tb_rf_move_seq;

    localparam int AW = 9;
    localparam int DW = 1408;
    localparam int LW = 8;
    localparam int NROW = 512;
    localparam int NO_HOLD = 9999;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        int            cyc;
    } wr_t;

    logic          clk;
    logic          rst_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [AW-1:0] cmd_src;
    logic [AW-1:0] cmd_dst;
    logic [LW-1:0] cmd_len;
    logic          cmd_src_inc;
    logic          cmd_dst_inc;
    logic          hold;
    logic          busy;
    logic          done;
    logic [AW-1:0] rf_addr;
    logic          rf_we;
    logic [DW-1:0] rf_d;
    logic [DW-1:0] rf_q;

    logic          dir_hold;
    logic          rnd_hold;
    logic          rand_hold;
    logic          init_go;
    int            cyc;
    int            tests;
    int            fails;

    logic [DW-1:0] rf_mem[NROW];
    logic [DW-1:0] model_mem[NROW];
    wr_t           wq[$];
    int            dq[$];

    rf_move_seq dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_src    (cmd_src),
        .cmd_dst    (cmd_dst),
        .cmd_len    (cmd_len),
        .cmd_src_inc(cmd_src_inc),
        .cmd_dst_inc(cmd_dst_inc),
        .hold       (hold),
        .busy       (busy),
        .done       (done),
        .rf_addr    (rf_addr),
        .rf_we      (rf_we),
        .rf_d       (rf_d),
        .rf_q       (rf_q)
    );

    assign hold = dir_hold | rnd_hold;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Register-file model: one-cycle read latency, write on rf_we.
    always @(posedge clk) begin
        if (init_go) begin
            for (int i = 0; i < NROW; i++)
                for (int w = 0; w < DW / 32; w++)
                    rf_mem[i][w*32 +: 32] <= $urandom;
        end else if (rf_we) begin
            rf_mem[rf_addr] <= rf_d;
        end
        rf_q <= rf_mem[rf_addr];
    end

    initial begin
        rnd_hold = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            rnd_hold = rand_hold && ($urandom_range(0, 3) == 0);
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_row(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got low64 %0h expected low64 %0h", nm, act[63:0], exp[63:0]);
        end
    endtask

    // Monitor: pops expected writes / done pulses as the DUT produces them.
    initial begin
        wr_t e;
        int  d;
        forever begin
            @(negedge clk);
            if (rf_we) begin
                chk("we_while_hold", {63'd0, hold}, 64'd0);
                if (wq.size() == 0) begin
                    chk("unexpected_write_addr", {55'd0, rf_addr}, 64'hFFFF);
                end else begin
                    e = wq.pop_front();
                    chk("wr_addr", {55'd0, rf_addr}, {55'd0, e.addr});
                    chk_row("wr_data", rf_d, e.data);
                    if (e.cyc >= 0) chk("wr_cycle", 64'(cyc), 64'(e.cyc));
                    model_mem[e.addr] = e.data;
                end
            end
            if (done) begin
                if (dq.size() == 0) begin
                    chk("unexpected_done_cycle", 64'(cyc), 64'hFFFF);
                end else begin
                    d = dq.pop_front();
                    if (d >= 0) chk("done_cycle", 64'(cyc), 64'(d));
                end
            end
        end
    end

    // Offer a command, wait for acceptance and queue the reference result.
    // Reference: rows are copied one at a time in order, so an overlapping
    // copy sees its own earlier writes.
    task automatic issue(input logic [AW-1:0] s, input logic [AW-1:0] d, input int l,
                         input bit si, input bit di, input bit timed, input int hold_row,
                         input bit keep, output int t);
        logic [DW-1:0] tmp[int];
        logic [AW-1:0] sa, da;
        wr_t           e;
        bit            acc;
        cmd_src     = s;
        cmd_dst     = d;
        cmd_len     = LW'(l);
        cmd_src_inc = si;
        cmd_dst_inc = di;
        cmd_valid   = 1'b1;
        acc = 1'b0;
        t   = -1;
        for (int n = 0; n < 2000 && !acc; n++) begin
            @(negedge clk);
            if (cmd_ready) begin
                acc = 1'b1;
                t   = cyc;
                for (int k = 0; k < l; k++) begin
                    sa = s + (si ? AW'(k) : AW'(0));
                    da = d + (di ? AW'(k) : AW'(0));
                    e.addr = da;
                    e.data = tmp.exists(int'(sa)) ? tmp[int'(sa)] : model_mem[sa];
                    tmp[int'(da)] = e.data;
                    e.cyc = timed ? (t + 2 + 2 * k + ((k >= hold_row) ? 2 : 0)) : -1;
                    wq.push_back(e);
                end
                dq.push_back(timed ? (t + 2 * l + 1 + ((hold_row < l) ? 2 : 0)) : -1);
            end
            @(posedge clk);
            #1;
        end
        if (!acc) chk("accept_timeout", 64'd1, 64'd0);
        if (!keep) cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 3000 && !ok; n++) begin
            @(negedge clk);
            if (!busy && wq.size() == 0 && dq.size() == 0) ok = 1'b1;
        end
        if (!ok) chk("idle_timeout", 64'd1, 64'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cyc(input int c);
        for (int n = 0; n < 1000 && cyc < c; n++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, tests %0d", tests);
        $fatal(1);
    end

    initial begin
        int            t, ta, tb;
        logic [DW-1:0] exp_rows[5];
        logic [DW-1:0] old_rows[5];
        tests = 0;
        fails = 0;
        cyc = 0;
        rand_hold = 1'b0;
        dir_hold = 1'b0;
        init_go = 1'b1;
        rst_n = 1'b0;
        cmd_valid = 1'b1;
        cmd_src = 9'h010;
        cmd_dst = 9'h020;
        cmd_len = 8'd3;
        cmd_src_inc = 1'b1;
        cmd_dst_inc = 1'b1;

        // Reset with a command offered: it must not be accepted.
        @(posedge clk);
        #1;
        init_go = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < NROW; i++) model_mem[i] = rf_mem[i];
        @(negedge clk);
        chk("rst_cmd_ready", {63'd0, cmd_ready}, 64'd1);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_rf_we", {63'd0, rf_we}, 64'd0);
        chk("rst_rf_addr", {55'd0, rf_addr}, 64'd0);
        chk("rst_rf_d_zero", {63'd0, |rf_d}, 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("rst_no_accept_busy", {63'd0, busy}, 64'd0);
        @(posedge clk);
        #1;

        // Copy 4 rows 0x10..0x13 -> 0x20..0x23.
        for (int i = 0; i < 4; i++) exp_rows[i] = rf_mem[9'h010 + i];
        issue(9'h010, 9'h020, 4, 1, 1, 1, NO_HOLD, 0, t);
        wait_idle();
        for (int i = 0; i < 4; i++) chk_row("copy_readback", rf_mem[9'h020 + i], exp_rows[i]);

        // Stream rows 0..2 into StMM X window 1.
        issue(9'h000, 9'h101, 3, 1, 0, 1, NO_HOLD, 0, t);
        wait_idle();

        // Zero-length command.
        issue(9'h030, 9'h040, 0, 1, 1, 1, NO_HOLD, 0, t);
        @(negedge clk);
        chk("len0_busy_t1", {63'd0, busy}, 64'd0);
        @(negedge clk);
        chk("len0_busy_t2", {63'd0, busy}, 64'd0);
        wait_idle();

        // Hold for one cycle in the WR of row 1.
        issue(9'h010, 9'h060, 3, 1, 1, 1, 1, 0, t);
        wait_cyc(t + 4);
        dir_hold = 1'b1;
        @(posedge clk);
        #1;
        dir_hold = 1'b0;
        wait_idle();

        // Source wrap 0x1FF -> 0x000.
        issue(9'h1FF, 9'h070, 2, 1, 1, 1, NO_HOLD, 0, t);
        wait_cyc(t + 3);
        @(negedge clk);
        chk("wrap_rd_addr", {55'd0, rf_addr}, 64'd0);
        chk("wrap_rd_we", {63'd0, rf_we}, 64'd0);
        wait_idle();

        // Back-to-back; the second command reads rows the first one wrote.
        issue(9'h080, 9'h090, 2, 1, 1, 1, NO_HOLD, 1, ta);
        issue(9'h090, 9'h0A0, 3, 1, 1, 1, NO_HOLD, 0, tb);
        chk("b2b_accept_cycle", 64'(tb), 64'(ta + 5));
        wait_idle();

        // Reset during the WR of row 2 of 5.
        for (int i = 0; i < 5; i++) begin
            old_rows[i] = rf_mem[9'h0B0 + i];
            exp_rows[i] = rf_mem[9'h0C0 + i];
        end
        issue(9'h0C0, 9'h0B0, 5, 1, 1, 1, NO_HOLD, 0, t);
        wait_cyc(t + 6);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        wq.delete();
        dq.delete();
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_rf_we", {63'd0, rf_we}, 64'd0);
        chk("midrst_busy", {63'd0, busy}, 64'd0);
        chk("midrst_cmd_ready", {63'd0, cmd_ready}, 64'd1);
        chk("midrst_done", {63'd0, done}, 64'd0);
        @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++)
            chk_row("midrst_dst_row", rf_mem[9'h0B0 + i], (i < 2) ? exp_rows[i] : old_rows[i]);
        for (int i = 0; i < NROW; i++) model_mem[i] = rf_mem[i];

        // Randomized commands with random hold.
        rand_hold = 1'b1;
        for (int n = 0; n < 25; n++) begin
            issue(AW'($urandom_range(0, NROW - 1)), AW'($urandom_range(0, NROW - 1)),
                  $urandom_range(0, 6), 1'($urandom), 1'($urandom), 0, NO_HOLD, 0, t);
        end
        wait_idle();
        rand_hold = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < NROW; i++) begin
            if (rf_mem[i] !== model_mem[i]) chk_row("final_mem_row", rf_mem[i], model_mem[i]);
        end
        chk("final_wq_empty", 64'(wq.size()), 64'd0);
        chk("final_dq_empty", 64'(dq.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
